// File: rtl/div_tick_controller.sv
// Programmable divide-by-D tick sequencer with start/stop, finite bursts and a one-deep divisor update.
// Define DIV_SQUARE_OUT_EN to add the sq_out square-wave output.
module div_tick_controller #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] run_len,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic [CNT_W-1:0] phase,
  output logic             busy,
  output logic             done
`ifdef DIV_SQUARE_OUT_EN
  ,
  output logic             sq_out
`endif
);

  localparam logic [CNT_W-1:0] DivRst = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] phase_q, phase_d;

  logic [CNT_W-1:0] d_eff;
  logic [CNT_W-1:0] d_m1;
  logic             wrap;
  logic [CNT_W-1:0] tick_cnt_nxt;

  // A stored divisor of 0 behaves as divide-by-1.
  assign d_eff = (div_q == '0) ? One : div_q;
  assign d_m1  = d_eff - One;
  assign wrap  = (phase_q == d_m1);

  assign tick      = (state_q == StRun) && (phase_q == '0);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign phase     = phase_q;
  assign cfg_ready = !pend_vld_q;

  // Count including the tick of this cycle, so D=1 bursts end after exactly L cycles.
  always_comb begin
    tick_cnt_nxt = tick_cnt_q;
    if (tick && (tick_cnt_q != '1)) begin
      tick_cnt_nxt = tick_cnt_q + One;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = '0;
    tick_cnt_d = tick_cnt_q;
    len_d      = len_q;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d    = StRun;
          tick_cnt_d = '0;
          len_d      = run_len;
        end
      end
      StRun: begin
        tick_cnt_d = tick_cnt_nxt;
        if (stop) begin
          state_d = StIdle;
        end else if (wrap && (len_q != '0) && (tick_cnt_nxt == len_q)) begin
          state_d = StDone;
        end else begin
          phase_d = wrap ? '0 : phase_q + One;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pending divisor lands at a period boundary while running so no period is cut short.
  always_comb begin
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    if (cfg_valid && cfg_ready) begin
      pend_div_d = cfg_div;
      pend_vld_d = 1'b1;
    end else if (pend_vld_q && ((state_q != StRun) || wrap)) begin
      div_d      = pend_div_q;
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      div_q      <= DivRst;
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      len_q      <= '0;
      tick_cnt_q <= '0;
      phase_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      len_q      <= len_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
    end
  end

`ifdef DIV_SQUARE_OUT_EN
  logic [CNT_W:0] half;

  // High for the first ceil(D/2) phases of each period.
  assign half   = ({1'b0, d_eff} + (CNT_W + 1)'(1)) >> 1;
  assign sq_out = (state_q == StRun) && ({1'b0, phase_q} < half);
`endif

endmodule
